// File: rtl/vlan_port_config_ctrl.sv
// Per-port VLAN configuration with shadow staging; staged entries reach the live
// untagger outputs only while the port is between frames.
module vlan_port_config_ctrl #(
    parameter int unsigned NUM_PORTS      = 8,
    parameter int unsigned DEFAULT_VLAN   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_wr_en,
    input  logic [3:0]                cfg_wr_port,
    input  logic [13:0]               cfg_wr_data,
    output logic                      cfg_wr_err,
    input  logic                      cfg_rd_en,
    input  logic [3:0]                cfg_rd_port,
    output logic                      cfg_rd_valid,
    output logic [14:0]               cfg_rd_data,
    input  logic [NUM_PORTS-1:0]      rx_start,
    input  logic [NUM_PORTS-1:0]      rx_commit,
    input  logic [NUM_PORTS-1:0]      rx_drop,
    output logic [12*NUM_PORTS-1:0]   port_vlan,
    output logic [NUM_PORTS-1:0]      tagged_allowed,
    output logic [NUM_PORTS-1:0]      untagged_allowed,
    output logic [NUM_PORTS-1:0]      cfg_pending
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [NUM_PORTS-1:0][13:0]     shadow_q, shadow_d;
    logic [NUM_PORTS-1:0][11:0]     vlan_q, vlan_d;
    logic [NUM_PORTS-1:0]           tag_q, tag_d;
    logic [NUM_PORTS-1:0]           untag_q, untag_d;
    logic [NUM_PORTS-1:0]           pending_q, pending_d;
    logic [NUM_PORTS-1:0]           in_frame_q, in_frame_d;
    logic [NUM_PORTS-1:0][CntW-1:0] cnt_q, cnt_d;
    logic                           wr_err_q, wr_err_d;
    logic                           rd_valid_q;
    logic [14:0]                    rd_data_q, rd_data_d;

    logic [11:0] wr_vlan;
    logic        wr_ok;

    always_comb begin
        wr_vlan  = cfg_wr_data[11:0];
        wr_ok    = cfg_wr_en && (32'(cfg_wr_port) < NUM_PORTS)
                   && (wr_vlan != 12'h000) && (wr_vlan != 12'hFFF);
        wr_err_d = cfg_wr_en && !wr_ok;
    end

    always_comb begin
        shadow_d   = shadow_q;
        vlan_d     = vlan_q;
        tag_d      = tag_q;
        untag_d    = untag_q;
        pending_d  = pending_q;
        in_frame_d = in_frame_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            // Apply reads the pre-edge shadow, so a same-cycle write stays pending.
            if (pending_q[i] && !in_frame_q[i] && !rx_start[i]) begin
                vlan_d[i]    = shadow_q[i][11:0];
                tag_d[i]     = shadow_q[i][12];
                untag_d[i]   = shadow_q[i][13];
                pending_d[i] = 1'b0;
            end
            if (wr_ok && (cfg_wr_port == 4'(i))) begin
                shadow_d[i]  = cfg_wr_data;
                pending_d[i] = 1'b1;
            end

            if (rx_start[i]) begin
                in_frame_d[i] = 1'b1;
                cnt_d[i]      = '0;
            end else if (rx_commit[i] || rx_drop[i]) begin
                in_frame_d[i] = 1'b0;
                cnt_d[i]      = '0;
            end else if (in_frame_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    in_frame_d[i] = 1'b0;
                    cnt_d[i]      = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (cfg_rd_en) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (cfg_rd_port == 4'(i)) begin
                    rd_data_d = {pending_q[i], untag_q[i], tag_q[i], vlan_q[i]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            vlan_q     <= {NUM_PORTS{12'(DEFAULT_VLAN)}};
            tag_q      <= '0;
            untag_q    <= '0;
            pending_q  <= '0;
            in_frame_q <= '0;
            cnt_q      <= '0;
            wr_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            shadow_q   <= shadow_d;
            vlan_q     <= vlan_d;
            tag_q      <= tag_d;
            untag_q    <= untag_d;
            pending_q  <= pending_d;
            in_frame_q <= in_frame_d;
            cnt_q      <= cnt_d;
            wr_err_q   <= wr_err_d;
            rd_valid_q <= cfg_rd_en;
            rd_data_q  <= rd_data_d;
        end
    end

    assign port_vlan        = vlan_q;
    assign tagged_allowed   = tag_q;
    assign untagged_allowed = untag_q;
    assign cfg_pending      = pending_q;
    assign cfg_wr_err       = wr_err_q;
    assign cfg_rd_valid     = rd_valid_q;
    assign cfg_rd_data      = rd_data_q;

endmodule

// File: tb/tb_vlan_port_config_ctrl.sv
// Directed bench for vlan_port_config_ctrl: staging, frame-gated apply, timeout,
// write rejection and reads, with hand-computed expectations.
module tb_vlan_port_config_ctrl;

    localparam int NP = 8;
    localparam int T  = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_wr_en;
    logic [3:0]       cfg_wr_port;
    logic [13:0]      cfg_wr_data;
    logic             cfg_wr_err;
    logic             cfg_rd_en;
    logic [3:0]       cfg_rd_port;
    logic             cfg_rd_valid;
    logic [14:0]      cfg_rd_data;
    logic [NP-1:0]    rx_start;
    logic [NP-1:0]    rx_commit;
    logic [NP-1:0]    rx_drop;
    logic [12*NP-1:0] port_vlan;
    logic [NP-1:0]    tagged_allowed;
    logic [NP-1:0]    untagged_allowed;
    logic [NP-1:0]    cfg_pending;

    int checks = 0;
    int errors = 0;

    vlan_port_config_ctrl #(
        .NUM_PORTS      (NP),
        .DEFAULT_VLAN   (1),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_wr_en        (cfg_wr_en),
        .cfg_wr_port      (cfg_wr_port),
        .cfg_wr_data      (cfg_wr_data),
        .cfg_wr_err       (cfg_wr_err),
        .cfg_rd_en        (cfg_rd_en),
        .cfg_rd_port      (cfg_rd_port),
        .cfg_rd_valid     (cfg_rd_valid),
        .cfg_rd_data      (cfg_rd_data),
        .rx_start         (rx_start),
        .rx_commit        (rx_commit),
        .rx_drop          (rx_drop),
        .port_vlan        (port_vlan),
        .tagged_allowed   (tagged_allowed),
        .untagged_allowed (untagged_allowed),
        .cfg_pending      (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [11:0] pv(input int p);
        return port_vlan[p*12 +: 12];
    endfunction

    task automatic wr(input int p, input logic u, input logic t, input logic [11:0] v);
        cfg_wr_en   = 1'b1;
        cfg_wr_port = 4'(p);
        cfg_wr_data = {u, t, v};
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic rd(input int p, input logic [14:0] exp, input string tag);
        cfg_rd_en   = 1'b1;
        cfg_rd_port = 4'(p);
        tick();
        cfg_rd_en   = 1'b0;
        check({tag, "_valid"}, cfg_rd_valid, 1'b1);
        check({tag, "_data"}, cfg_rd_data, exp);
        tick();
        check({tag, "_valid_drop"}, cfg_rd_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_port = '0; cfg_wr_data = '0;
        cfg_rd_en = 1'b0; cfg_rd_port = '0;
        rx_start = '0; rx_commit = '0; rx_drop = '0;
        tick(2);
        rst = 1'b0;

        // Reset state
        check("rst_vlan", port_vlan, {NP{12'd1}});
        check("rst_tag", tagged_allowed, 8'h00);
        check("rst_untag", untagged_allowed, 8'h00);
        check("rst_pending", cfg_pending, 8'h00);
        check("rst_wr_err", cfg_wr_err, 1'b0);
        check("rst_rd_valid", cfg_rd_valid, 1'b0);
        rd(3, 15'h0001, "rd_p3_reset");

        // Idle port: write -> pending at N+1 -> live at N+2
        wr(2, 1'b1, 1'b0, 12'd42);
        check("p2_pending_n1", cfg_pending, 8'h04);
        check("p2_vlan_n1", pv(2), 12'd1);
        check("p2_wr_err_ok", cfg_wr_err, 1'b0);
        tick();
        check("p2_vlan_n2", pv(2), 12'd42);
        check("p2_untag_n2", untagged_allowed, 8'h04);
        check("p2_tag_n2", tagged_allowed, 8'h00);
        check("p2_pending_n2", cfg_pending, 8'h00);
        rd(2, 15'h202A, "rd_p2");

        // Busy port 0: apply waits for commit, then the cycle after
        rx_start[0] = 1'b1; tick(); rx_start[0] = 1'b0;
        tick();
        wr(0, 1'b1, 1'b1, 12'd100);
        tick(10);
        check("p0_vlan_in_frame", pv(0), 12'd1);
        check("p0_pending_in_frame", cfg_pending[0], 1'b1);
        rx_commit[0] = 1'b1; tick(); rx_commit[0] = 1'b0;
        check("p0_vlan_at_commit", pv(0), 12'd1);
        tick();
        check("p0_vlan_applied", pv(0), 12'd100);
        check("p0_tag_applied", tagged_allowed[0], 1'b1);
        check("p0_pending_clr", cfg_pending[0], 1'b0);

        // Start right after commit blocks the apply; next frame ends with drop
        rx_start[0] = 1'b1; tick(); rx_start[0] = 1'b0;
        wr(0, 1'b1, 1'b1, 12'd200);
        tick(3);
        rx_commit[0] = 1'b1; tick(); rx_commit[0] = 1'b0;
        rx_start[0]  = 1'b1; tick(); rx_start[0]  = 1'b0;
        check("p0_no_apply_on_start", pv(0), 12'd100);
        tick(5);
        check("p0_deferred_vlan", pv(0), 12'd100);
        check("p0_deferred_pending", cfg_pending[0], 1'b1);
        rx_drop[0] = 1'b1; tick(); rx_drop[0] = 1'b0;
        check("p0_vlan_at_drop", pv(0), 12'd100);
        tick();
        check("p0_vlan_after_drop", pv(0), 12'd200);
        rd(0, 15'h30C8, "rd_p0");

        // Rejected writes: one-cycle error pulse, no state change
        wr(5, 1'b1, 1'b1, 12'h000);
        check("bad_v0_err", cfg_wr_err, 1'b1);
        check("bad_v0_pending", cfg_pending, 8'h00);
        tick();
        check("bad_v0_err_drop", cfg_wr_err, 1'b0);
        wr(5, 1'b1, 1'b1, 12'hFFF);
        check("bad_vfff_err", cfg_wr_err, 1'b1);
        check("bad_vfff_pending", cfg_pending, 8'h00);
        tick();
        check("bad_vfff_err_drop", cfg_wr_err, 1'b0);
        wr(9, 1'b1, 1'b1, 12'd10);
        check("bad_port_err", cfg_wr_err, 1'b1);
        check("bad_port_pending", cfg_pending, 8'h00);
        tick();
        check("bad_port_err_drop", cfg_wr_err, 1'b0);
        check("bad_vlan_snapshot", port_vlan,
              {12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd42, 12'd1, 12'd200});
        check("bad_tag_snapshot", tagged_allowed, 8'h01);
        check("bad_untag_snapshot", untagged_allowed, 8'h05);
        rd(12, 15'h0000, "rd_oob");

        // Read and write in the same cycle are independent
        cfg_rd_en = 1'b1; cfg_rd_port = 4'd2;
        wr(6, 1'b0, 1'b1, 12'd300);
        cfg_rd_en = 1'b0;
        check("rdwr_rd_data", cfg_rd_data, 15'h202A);
        check("rdwr_pending", cfg_pending, 8'h40);
        tick();
        check("rdwr_p6_vlan", pv(6), 12'd300);

        // Lost commit: timeout force-clears the frame, then the config applies
        rx_start[1] = 1'b1; tick(); rx_start[1] = 1'b0;
        wr(1, 1'b0, 1'b1, 12'd77);
        tick(T - 2);
        check("to_before_vlan", pv(1), 12'd1);
        tick();
        check("to_cleared_vlan", pv(1), 12'd1);
        check("to_cleared_pending", cfg_pending[1], 1'b1);
        tick();
        check("to_applied_vlan", pv(1), 12'd77);
        check("to_applied_tag", tagged_allowed[1], 1'b1);
        check("to_applied_pending", cfg_pending[1], 1'b0);

        // Last write wins while the frame is open
        rx_start[4] = 1'b1; tick(); rx_start[4] = 1'b0;
        wr(4, 1'b0, 1'b1, 12'd5);
        wr(4, 1'b0, 1'b1, 12'd6);
        tick();
        check("lww_in_frame", pv(4), 12'd1);
        rx_commit[4] = 1'b1; tick(); rx_commit[4] = 1'b0;
        check("lww_at_commit", pv(4), 12'd1);
        tick();
        check("lww_applied", pv(4), 12'd6);
        tick();
        check("lww_stable", pv(4), 12'd6);
        check("lww_pending", cfg_pending, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
